// File: rtl/lsu_pkg.sv
// Shared LSU definitions: load/store func3 encodings, store FSM states, request record.
package lsu_pkg;
    // Store widths
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    // Load widths (used by the load filter)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_REJ   = 2'd3
    } st_state_e;

    typedef struct packed {
        logic [2:0]  func3;
        logic [31:0] addr;
        logic [31:0] data;
    } st_req_t;
endpackage

// File: rtl/st_lane_gen.sv
// Combinational store lane generator: byte-lane shift, strobes and split/illegal detection.
module st_lane_gen
    import lsu_pkg::*;
#(
    parameter int MISALIGN_EN = 1
) (
    input  logic [2:0]  func3,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    input  logic        beat,      // 0: first beat, 1: spill beat into next word
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        crossing,
    output logic        illegal
);
    logic       legal;
    logic [3:0] mask;
    logic [2:0] size;
    logic [2:0] rem;
    logic [7:0] strb_wide;

    // Decode width, then place data/strobes for the selected beat
    always_comb begin
        legal = 1'b1;
        mask  = 4'b0000;
        size  = 3'd0;
        case (func3)
            F3_SB:   begin mask = 4'b0001; size = 3'd1; end
            F3_SH:   begin mask = 4'b0011; size = 3'd2; end
            F3_SW:   begin mask = 4'b1111; size = 3'd4; end
            default: legal = 1'b0;
        endcase
        crossing  = legal && (({1'b0, off} + size) > 3'd4);
        illegal   = !legal || (crossing && (MISALIGN_EN == 0));
        rem       = 3'd4 - {1'b0, off};
        strb_wide = {4'b0000, mask} << off;
        if (!beat) begin
            wdata = st_data << {off, 3'b000};
            wstrb = strb_wide[3:0];
        end else begin
            // rem is 1..3 whenever a second beat exists
            wdata = st_data >> {rem, 3'b000};
            wstrb = mask >> rem;
        end
    end
endmodule

// File: rtl/st_align_unit.sv
// Store alignment unit: latches a store, issues one or two aligned write beats,
// then returns a registered done/error pulse.
module st_align_unit
    import lsu_pkg::*;
#(
    parameter int MISALIGN_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        st_done,
    output logic        st_err
);
    st_state_e   state_q, state_d;
    st_req_t     req_q, req_d;
    st_req_t     lane_req;
    logic        done_q, done_d;
    logic        in_idle, in_beat1, hs;
    logic [31:0] lane_wdata, word_addr;
    logic [3:0]  lane_wstrb;
    logic        lane_cross, lane_illegal;

    assign in_idle  = (state_q == ST_IDLE);
    assign in_beat1 = (state_q == ST_BEAT1);

    // In IDLE the lane generator classifies the incoming request; afterwards it
    // works from the latched copy. mem_* are forced to zero in IDLE, so request
    // inputs never reach the write port combinationally.
    always_comb begin
        lane_req = in_idle ? st_req_t'{func3: func3, addr: addr, data: st_data} : req_q;
    end

    st_lane_gen #(.MISALIGN_EN(MISALIGN_EN)) u_lane (
        .func3    (lane_req.func3),
        .off      (lane_req.addr[1:0]),
        .st_data  (lane_req.data),
        .beat     (in_beat1),
        .wdata    (lane_wdata),
        .wstrb    (lane_wstrb),
        .crossing (lane_cross),
        .illegal  (lane_illegal)
    );

    // Write-port drive; zero whenever no beat is in flight
    always_comb begin
        mem_valid = (state_q == ST_BEAT0) || in_beat1;
        word_addr = {req_q.addr[31:2], 2'b00};
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        if (mem_valid) begin
            mem_addr  = in_beat1 ? word_addr + 32'd4 : word_addr;
            mem_wdata = lane_wdata;
            mem_wstrb = lane_wstrb;
        end
        hs        = mem_valid && mem_ready;
        req_ready = in_idle;
        st_done   = done_q || (state_q == ST_REJ);
        st_err    = (state_q == ST_REJ);
    end

    // Next-state, request capture and completion pulse
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                req_d   = lane_req;
                state_d = lane_illegal ? ST_REJ : ST_BEAT0;
            end
            ST_BEAT0: if (hs) begin
                state_d = lane_cross ? ST_BEAT1 : ST_IDLE;
                done_d  = !lane_cross;
            end
            ST_BEAT1: if (hs) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with async active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            done_q  <= done_d;
        end
    end
endmodule
